// File: rtl/flash_wb_arb_if.sv
// Wishbone classic bus bundle shared by the two masters and the flash slave port.
// The master modport is the initiator's view; the slave modport is the target's view.
interface flash_wb_arb_if;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [3:0]  sel;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] dat_r;
  logic        ack;
  logic        err;

  modport master (
    output adr, dat_w, sel, cyc, stb, we,
    input  dat_r, ack, err
  );

  modport slave (
    input  adr, dat_w, sel, cyc, stb, we,
    output dat_r, ack, err
  );
endinterface

// File: rtl/flash_wb_arb.sv
// Round-robin two-master Wishbone arbiter in front of the flash slave, with the
// grant locked for a whole cyc and a per-access watchdog that returns err on a stall.
module flash_wb_arb #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_n_i,
  flash_wb_arb_if.slave  m0,
  flash_wb_arb_if.slave  m1,
  flash_wb_arb_if.master s
);

  typedef enum logic [1:0] {StIdle, StGnt0, StGnt1} state_e;

  state_e             state_q;
  logic               last_gnt_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               gnt0;
  logic               gnt1;
  logic               own_cyc;
  logic               own_stb;
  logic               timeout;
  logic               wd_err;

  assign gnt0 = (state_q == StGnt0);
  assign gnt1 = (state_q == StGnt1);

  // Slave-side mux: owner's signals pass straight through, IDLE drives zeros.
  always_comb begin
    s.adr   = '0;
    s.dat_w = '0;
    s.sel   = '0;
    s.we    = 1'b0;
    own_cyc = 1'b0;
    own_stb = 1'b0;
    unique case (state_q)
      StGnt0: begin
        s.adr   = m0.adr;
        s.dat_w = m0.dat_w;
        s.sel   = m0.sel;
        s.we    = m0.we;
        own_cyc = m0.cyc;
        own_stb = m0.stb;
      end
      StGnt1: begin
        s.adr   = m1.adr;
        s.dat_w = m1.dat_w;
        s.sel   = m1.sel;
        s.we    = m1.we;
        own_cyc = m1.cyc;
        own_stb = m1.stb;
      end
      default: ;
    endcase
  end

  // The strobe is withheld on the timeout cycle, so it never depends on the slave's
  // combinational ack and no loop forms through a zero-wait slave.
  assign timeout = (state_q != StIdle) && (cnt_q == CNT_W'(TIMEOUT));
  assign s.cyc   = own_cyc;
  assign s.stb   = own_stb & ~timeout;
  assign wd_err  = own_stb & timeout & ~s.ack & ~s.err;

  assign m0.ack   = gnt0 & s.ack;
  assign m0.err   = gnt0 & (s.err | wd_err);
  assign m0.dat_r = s.dat_r;
  assign m1.ack   = gnt1 & s.ack;
  assign m1.err   = gnt1 & (s.err | wd_err);
  assign m1.dat_r = s.dat_r;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q    <= StIdle;
      last_gnt_q <= 1'b1;
      cnt_q      <= '0;
    end else begin
      // Owner dropping cyc is exactly when the state leaves a grant, so it clears too.
      if (own_cyc && own_stb && !s.ack && !s.err && !timeout) begin
        cnt_q <= cnt_q + 1'b1;
      end else begin
        cnt_q <= '0;
      end

      unique case (state_q)
        StIdle: begin
          if (m0.cyc && (!m1.cyc || last_gnt_q)) begin
            state_q    <= StGnt0;
            last_gnt_q <= 1'b0;
          end else if (m1.cyc) begin
            state_q    <= StGnt1;
            last_gnt_q <= 1'b1;
          end
        end
        StGnt0: begin
          if (!m0.cyc) begin
            if (m1.cyc) begin
              state_q    <= StGnt1;
              last_gnt_q <= 1'b1;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        StGnt1: begin
          if (!m1.cyc) begin
            if (m0.cyc) begin
              state_q    <= StGnt0;
              last_gnt_q <= 1'b0;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_wb_arb.sv
// Randomized bench for flash_wb_arb: directed scenarios plus random traffic, all
// checked against a cycle-level ownership/watchdog reference model.
module tb_flash_wb_arb;
  localparam int unsigned TIMEOUT = 4;
  localparam int unsigned CNT_W   = 3;
  localparam logic [31:0] ERR_ADR = 32'h00E0_0000;
  localparam logic [31:0] KEY     = 32'hA5A5_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ack_en = 1'b1;
  int   checks = 0;
  int   failures = 0;

  // Reference model state: owner -1 = nobody, last = last granted master.
  int   owner = -1;
  int   last = 1;
  int   wd = 0;

  always #5 clk = ~clk;

  flash_wb_arb_if m0_bus ();
  flash_wb_arb_if m1_bus ();
  flash_wb_arb_if s_bus ();

  flash_wb_arb #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .m0         (m0_bus),
    .m1         (m1_bus),
    .s          (s_bus)
  );

  // Zero-wait flash model: errors on one magic address, otherwise acks when enabled.
  always_comb begin
    s_bus.dat_r = s_bus.adr ^ KEY;
    s_bus.err   = s_bus.stb && (s_bus.adr == ERR_ADR);
    s_bus.ack   = s_bus.stb && ack_en && (s_bus.adr != ERR_ADR);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input int idx, input bit cyc, input bit stb, input bit we,
                       input logic [31:0] adr);
    if (idx == 0) begin
      m0_bus.cyc = cyc; m0_bus.stb = stb; m0_bus.we = we; m0_bus.adr = adr;
      m0_bus.dat_w = $urandom; m0_bus.sel = 4'($urandom);
    end else begin
      m1_bus.cyc = cyc; m1_bus.stb = stb; m1_bus.we = we; m1_bus.adr = adr;
      m1_bus.dat_w = $urandom; m1_bus.sel = 4'($urandom);
    end
  endtask

  // Compare the DUT against the model for this cycle, then advance the model.
  task automatic eval();
    logic [31:0] e_adr, e_dw;
    logic [3:0]  e_sel;
    bit e_cyc, e_we, ms, tmo, e_stb, s_a, s_e;
    bit a0, e0, a1, e1;
    bit c0, c1;
    int nxt;
    e_adr = '0; e_dw = '0; e_sel = '0; e_cyc = 0; e_we = 0; ms = 0;
    a0 = 0; e0 = 0; a1 = 0; e1 = 0;
    if (!rst_n) begin
      owner = -1; last = 1; wd = 0;
    end
    if (owner == 0) begin
      e_adr = m0_bus.adr; e_dw = m0_bus.dat_w; e_sel = m0_bus.sel;
      e_cyc = m0_bus.cyc; e_we = m0_bus.we; ms = m0_bus.stb;
    end else if (owner == 1) begin
      e_adr = m1_bus.adr; e_dw = m1_bus.dat_w; e_sel = m1_bus.sel;
      e_cyc = m1_bus.cyc; e_we = m1_bus.we; ms = m1_bus.stb;
    end
    tmo   = (owner >= 0) && (wd == TIMEOUT);
    e_stb = ms && !tmo;
    s_e   = e_stb && (e_adr == ERR_ADR);
    s_a   = e_stb && ack_en && !s_e;
    if (owner == 0) begin a0 = s_a; e0 = s_e || (ms && tmo); end
    if (owner == 1) begin a1 = s_a; e1 = s_e || (ms && tmo); end

    check_eq("s_cyc", 32'(s_bus.cyc), 32'(e_cyc));
    check_eq("s_stb", 32'(s_bus.stb), 32'(e_stb));
    check_eq("s_we", 32'(s_bus.we), 32'(e_we));
    check_eq("s_adr", s_bus.adr, e_adr);
    check_eq("s_dat", s_bus.dat_w, e_dw);
    check_eq("s_sel", 32'(s_bus.sel), 32'(e_sel));
    check_eq("m0_ack", 32'(m0_bus.ack), 32'(a0));
    check_eq("m0_err", 32'(m0_bus.err), 32'(e0));
    check_eq("m1_ack", 32'(m1_bus.ack), 32'(a1));
    check_eq("m1_err", 32'(m1_bus.err), 32'(e1));
    if (a0 || a1) begin
      check_eq("m0_rdat", m0_bus.dat_r, e_adr ^ KEY);
      check_eq("m1_rdat", m1_bus.dat_r, e_adr ^ KEY);
    end

    if (rst_n) begin
      c0 = m0_bus.cyc;
      c1 = m1_bus.cyc;
      if (owner < 0) nxt = (c0 && c1) ? (last == 0 ? 1 : 0) : (c0 ? 0 : (c1 ? 1 : -1));
      else if (owner == 0) nxt = c0 ? 0 : (c1 ? 1 : -1);
      else nxt = c1 ? 1 : (c0 ? 0 : -1);
      if (nxt != owner || owner < 0 || !ms || s_a || s_e || tmo) wd = 0;
      else wd++;
      if (nxt >= 0 && nxt != owner) last = nxt;
      owner = nxt;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    eval();
    @(posedge clk);
    #1;
  endtask

  bit rc[2];
  bit rs[2];

  initial begin
    drive(0, 0, 0, 0, '0);
    drive(1, 0, 0, 0, '0);

    // Reset holds everything off even with a master requesting.
    drive(0, 1, 1, 0, 32'h100);
    #12;
    check_eq("rst_s_cyc", 32'(s_bus.cyc), 0);
    check_eq("rst_s_stb", 32'(s_bus.stb), 0);
    check_eq("rst_s_adr", s_bus.adr, 0);
    check_eq("rst_m0_ack", 32'(m0_bus.ack), 0);
    check_eq("rst_m0_err", 32'(m0_bus.err), 0);
    check_eq("rst_m0_dat", m0_bus.dat_r, KEY);
    drive(0, 0, 0, 0, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle();

    // Single master read with a zero-wait ack.
    drive(0, 1, 1, 0, 32'h100);
    repeat (3) cycle();
    drive(0, 0, 0, 0, '0);
    cycle();

    // Tie, handover without bubble, then a second tie goes back to m0.
    drive(0, 1, 1, 0, 32'h200);
    drive(1, 1, 1, 1, 32'h300);
    repeat (3) cycle();
    drive(0, 0, 0, 0, '0);
    repeat (3) cycle();
    drive(1, 0, 0, 0, '0);
    cycle();
    drive(0, 1, 1, 0, 32'h204);
    drive(1, 1, 1, 0, 32'h304);
    repeat (3) cycle();
    drive(0, 0, 0, 0, '0);
    drive(1, 0, 0, 0, '0);
    repeat (2) cycle();

    // Locked burst on m1 while m0 waits.
    drive(1, 1, 1, 0, 32'h10);
    cycle();
    drive(0, 1, 1, 0, 32'h400);
    for (int k = 0; k < 4; k++) begin
      drive(1, 1, 1, 0, 32'h10 + 32'(4 * k));
      cycle();
    end
    drive(1, 0, 0, 0, '0);
    repeat (3) cycle();
    drive(0, 0, 0, 0, '0);
    cycle();

    // Watchdog with a slave that never answers.
    ack_en = 1'b0;
    drive(0, 1, 1, 0, 32'h500);
    repeat (12) cycle();
    drive(0, 0, 0, 0, '0);
    ack_en = 1'b1;
    cycle();

    // Slave error goes only to the owner.
    drive(0, 1, 1, 0, ERR_ADR);
    drive(1, 1, 1, 0, 32'h600);
    repeat (4) cycle();
    drive(0, 0, 0, 0, '0);
    drive(1, 0, 0, 0, '0);
    repeat (2) cycle();

    // Asynchronous reset in the middle of an m1 read.
    ack_en = 1'b0;
    drive(1, 1, 1, 0, 32'h700);
    repeat (3) cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_s_cyc", 32'(s_bus.cyc), 0);
    check_eq("arst_s_stb", 32'(s_bus.stb), 0);
    check_eq("arst_s_adr", s_bus.adr, 0);
    check_eq("arst_m1_ack", 32'(m1_bus.ack), 0);
    check_eq("arst_m1_err", 32'(m1_bus.err), 0);
    owner = -1; last = 1; wd = 0;
    rst_n = 1'b1;
    ack_en = 1'b1;
    repeat (3) cycle();
    drive(1, 0, 0, 0, '0);
    cycle();

    // Random traffic with stalling phases to exercise the watchdog.
    rc[0] = 0; rc[1] = 0; rs[0] = 0; rs[1] = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom % 20 == 0) ack_en = ($urandom % 3 != 0);
      for (int i = 0; i < 2; i++) begin
        if (!rc[i]) begin
          rc[i] = ($urandom % 4 == 0);
          rs[i] = rc[i] && ($urandom % 2 == 0);
        end else if ($urandom % 10 == 0) begin
          rc[i] = 0;
          rs[i] = 0;
        end else if (!rs[i]) begin
          rs[i] = ($urandom % 2 == 0);
        end else if ($urandom % 8 == 0) begin
          rs[i] = 0;
        end
        drive(i, rc[i], rs[i], 1'($urandom),
              ($urandom % 6 == 0) ? ERR_ADR : ($urandom & 32'hFFFF_FFFC));
      end
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
